// File: rtl/rprelu_pkg.sv
// Shared state encoding and sizing helpers for the RPReLU parameter loader.
// Mode/valid encodings are kept in sync with the project-wide defines.v.
`ifndef RPRELU_DEFINES_V
`define RPRELU_DEFINES_V
`define PARA_WIDTH 16
`define RELOAD     1'b0
`define CALCULATE  1'b1
`define RSTVALID   1'b0
`define DATAVALID  1'b1
`endif

package rprelu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_BETA,
        LOAD_GAMMA,
        LOAD_ZETA,
        DONE
    } state_t;

    localparam int DEF_CHANNEL_NUM = 512;
    localparam int DEF_LANES       = 8;
    localparam int BEATS           = DEF_CHANNEL_NUM / DEF_LANES;

    // A single-beat bank still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/rprelu_para_bank.sv
// One per-channel parameter bank: CHANNEL_NUM registers written LANES at a time.
import rprelu_pkg::*;

module rprelu_para_bank #(
    parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
    parameter int LANES       = DEF_LANES,
    parameter int CNT_W       = cnt_width(DEF_CHANNEL_NUM / DEF_LANES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [CNT_W-1:0]              beat_idx,
    input  logic [LANES*`PARA_WIDTH-1:0]  wr_data,
    output logic signed [`PARA_WIDTH-1:0] bank [CHANNEL_NUM-1:0]
);

    localparam int BEATS_N = CHANNEL_NUM / LANES;

    // Each entry owns its own decode so a beat touches exactly LANES registers.
    for (genvar gi = 0; gi < BEATS_N; gi++) begin : g_beat
        for (genvar gj = 0; gj < LANES; gj++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    bank[gi*LANES + gj] <= '0;
                else if (we && (beat_idx == CNT_W'(gi)))
                    bank[gi*LANES + gj] <= wr_data[gj*`PARA_WIDTH +: `PARA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rprelu_para_loader.sv
// Loads beta, gamma and zeta banks from a valid/ready word stream while in RELOAD
// and holds them stable for the RPReLU stage during CALCULATE.
import rprelu_pkg::*;

module rprelu_para_loader #(
    parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
    parameter int LANES       = DEF_LANES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic [LANES*`PARA_WIDTH-1:0]  para_in,
    input  logic                          para_valid,
    output logic                          para_ready,
    output logic signed [`PARA_WIDTH-1:0] rprelu_beta  [CHANNEL_NUM-1:0],
    output logic signed [`PARA_WIDTH-1:0] rprelu_gamma [CHANNEL_NUM-1:0],
    output logic signed [`PARA_WIDTH-1:0] rprelu_zeta  [CHANNEL_NUM-1:0],
    output logic                          para_done,
    output logic                          params_valid,
    output logic                          load_err
);

    localparam int BEATS_N = CHANNEL_NUM / LANES;
    localparam int CNT_W   = cnt_width(BEATS_N);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             params_valid_reg, params_valid_next;
    logic             load_err_reg, load_err_next;

    logic loading;
    logic accept;
    logic cnt_last;

    assign loading    = (state_reg == LOAD_BETA) || (state_reg == LOAD_GAMMA) ||
                        (state_reg == LOAD_ZETA);
    assign para_ready = loading && (mode == `RELOAD);
    assign accept     = para_ready && (para_valid == `DATAVALID);
    assign cnt_last   = (cnt_reg == CNT_W'(BEATS_N - 1));

    assign para_done    = (state_reg == DONE);
    assign params_valid = params_valid_reg;
    assign load_err     = load_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            params_valid_reg <= 1'b0;
            load_err_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            params_valid_reg <= params_valid_next;
            load_err_reg     <= load_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        params_valid_next = params_valid_reg;
        load_err_next     = load_err_reg;
        case (state_reg)
            IDLE: begin
                if (mode == `RELOAD) begin
                    state_next        = LOAD_BETA;
                    cnt_next          = '0;
                    params_valid_next = 1'b0;
                    load_err_next     = 1'b0;
                end
            end
            LOAD_BETA, LOAD_GAMMA, LOAD_ZETA: begin
                // Leaving RELOAD mid-load aborts; partial bank contents stay as written.
                if (mode == `CALCULATE) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    load_err_next = 1'b1;
                end else if (accept) begin
                    if (cnt_last) begin
                        cnt_next = '0;
                        case (state_reg)
                            LOAD_BETA:  state_next = LOAD_GAMMA;
                            LOAD_GAMMA: state_next = LOAD_ZETA;
                            default: begin
                                state_next        = DONE;
                                params_valid_next = 1'b1;
                            end
                        endcase
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                if (mode == `CALCULATE)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    rprelu_para_bank #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .LANES       (LANES),
        .CNT_W       (CNT_W)
    ) u_beta_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (accept && (state_reg == LOAD_BETA)),
        .beat_idx (cnt_reg),
        .wr_data  (para_in),
        .bank     (rprelu_beta)
    );

    rprelu_para_bank #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .LANES       (LANES),
        .CNT_W       (CNT_W)
    ) u_gamma_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (accept && (state_reg == LOAD_GAMMA)),
        .beat_idx (cnt_reg),
        .wr_data  (para_in),
        .bank     (rprelu_gamma)
    );

    rprelu_para_bank #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .LANES       (LANES),
        .CNT_W       (CNT_W)
    ) u_zeta_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (accept && (state_reg == LOAD_ZETA)),
        .beat_idx (cnt_reg),
        .wr_data  (para_in),
        .bank     (rprelu_zeta)
    );

endmodule

// File: tb/tb_rprelu_para_loader.sv
// Directed bench for rprelu_para_loader: reset, full/throttled loads, abort,
// ignored beats in DONE and asynchronous reset mid-load.
import rprelu_pkg::*;

module tb_rprelu_para_loader;

    localparam int CH = 512;
    localparam int LN = 8;
    localparam int PW = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [LN*PW-1:0]     para_in;
    logic                 para_valid;
    logic                 para_ready;
    logic signed [PW-1:0] beta  [CH-1:0];
    logic signed [PW-1:0] gamma [CH-1:0];
    logic signed [PW-1:0] zeta  [CH-1:0];
    logic                 para_done;
    logic                 params_valid;
    logic                 load_err;

    int checks   = 0;
    int failures = 0;

    rprelu_para_loader #(
        .CHANNEL_NUM (CH),
        .LANES       (LN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .para_in      (para_in),
        .para_valid   (para_valid),
        .para_ready   (para_ready),
        .rprelu_beta  (beta),
        .rprelu_gamma (gamma),
        .rprelu_zeta  (zeta),
        .para_done    (para_done),
        .params_valid (params_valid),
        .load_err     (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected value of entry i is base + inc*i over [lo, hi] of the selected bank.
    task automatic cmp_range(input string tag, input int sel, input int lo, input int hi,
                             input int base, input int inc);
        int          bad = 0;
        logic [15:0] obs, exp, first_obs, first_exp;
        first_obs = '0;
        first_exp = '0;
        for (int i = lo; i <= hi; i++) begin
            obs = (sel == 0) ? beta[i] : (sel == 1) ? gamma[i] : zeta[i];
            exp = 16'(base + inc * i);
            if (obs !== exp) begin
                if (bad == 0) begin
                    first_obs = obs;
                    first_exp = exp;
                end
                bad++;
            end
        end
        checks++;
        assert (bad == 0) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h bad_entries=%0d", tag, first_obs, first_exp, bad);
        end
    endtask

    // Called at a negedge with the loader in a LOAD state; returns at a negedge.
    task automatic do_beats(input int start, input int n, input int base, input bit throttle);
        for (int b = start; b < start + n; b++) begin
            if (throttle) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    para_valid = 1'b0;
                    para_in    = '1;
                    @(negedge clk);
                end
            end
            para_valid = 1'b1;
            for (int k = 0; k < LN; k++)
                para_in[k*PW +: PW] = 16'(base + b*LN + k);
            @(negedge clk);
        end
        para_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 1'b1;
        para_in    = '0;
        para_valid = 1'b0;

        // Reset, then CALCULATE with stray valid pulses
        #2;
        check("rst_ready", 16'(para_ready), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rel", 16'(para_ready), 16'h0);
        check("rst_done", 16'(para_done), 16'h0);
        check("rst_pvalid", 16'(params_valid), 16'h0);
        check("rst_err", 16'(load_err), 16'h0);
        cmp_range("rst_beta", 0, 0, CH-1, 0, 0);
        cmp_range("rst_gamma", 1, 0, CH-1, 0, 0);
        cmp_range("rst_zeta", 2, 0, CH-1, 0, 0);
        para_valid = 1'b1;
        para_in    = '1;
        repeat (3) @(negedge clk);
        para_valid = 1'b0;
        cmp_range("calc_pulse_beta", 0, 0, CH-1, 0, 0);
        $display("step reset: checks=%0d failures=%0d", checks, failures);

        // Full back-to-back load
        mode = 1'b0;
        @(negedge clk);
        check("full_ready", 16'(para_ready), 16'h1);
        do_beats(0, 3*BEATS - 1, 0, 1'b0);
        check("full_done_early", 16'(para_done), 16'h0);
        do_beats(3*BEATS - 1, 1, 0, 1'b0);
        check("full_done", 16'(para_done), 16'h1);
        check("full_pvalid", 16'(params_valid), 16'h1);
        check("full_ready_done", 16'(para_ready), 16'h0);
        check("beta5", 16'(beta[5]), 16'd5);
        check("gamma0", 16'(gamma[0]), 16'd512);
        check("zeta511", 16'(zeta[511]), 16'd1535);
        cmp_range("full_beta", 0, 0, CH-1, 0, 1);
        cmp_range("full_gamma", 1, 0, CH-1, 512, 1);
        cmp_range("full_zeta", 2, 0, CH-1, 1024, 1);
        $display("step full load: checks=%0d failures=%0d", checks, failures);

        // Extra beats while DONE are refused
        para_valid = 1'b1;
        para_in    = '1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("done_ready", 16'(para_ready), 16'h0);
            @(negedge clk);
        end
        para_valid = 1'b0;
        cmp_range("done_beta", 0, 0, CH-1, 0, 1);
        cmp_range("done_gamma", 1, 0, CH-1, 512, 1);
        cmp_range("done_zeta", 2, 0, CH-1, 1024, 1);
        mode = 1'b1;
        @(negedge clk);
        check("calc_done", 16'(para_done), 16'h0);
        check("calc_pvalid", 16'(params_valid), 16'h1);
        $display("step done/calculate: checks=%0d failures=%0d", checks, failures);

        // Throttled load with the same data
        mode = 1'b0;
        @(negedge clk);
        check("thr_pvalid_clr", 16'(params_valid), 16'h0);
        do_beats(0, 3*BEATS, 0, 1'b1);
        check("thr_done", 16'(para_done), 16'h1);
        check("thr_pvalid", 16'(params_valid), 16'h1);
        cmp_range("thr_beta", 0, 0, CH-1, 0, 1);
        cmp_range("thr_gamma", 1, 0, CH-1, 512, 1);
        cmp_range("thr_zeta", 2, 0, CH-1, 1024, 1);
        mode = 1'b1;
        @(negedge clk);
        $display("step throttled load: checks=%0d failures=%0d", checks, failures);

        // Abort after 70 beats of new data (offset 0x4000)
        mode = 1'b0;
        @(negedge clk);
        do_beats(0, 70, 16'h4000, 1'b0);
        mode       = 1'b1;
        para_valid = 1'b1;
        para_in    = '1;
        #1;
        check("abort_ready", 16'(para_ready), 16'h0);
        @(negedge clk);
        para_valid = 1'b0;
        check("abort_err", 16'(load_err), 16'h1);
        check("abort_pvalid", 16'(params_valid), 16'h0);
        check("abort_done", 16'(para_done), 16'h0);
        cmp_range("abort_beta", 0, 0, CH-1, 16'h4000, 1);
        cmp_range("abort_gamma_lo", 1, 0, 47, 16'h4200, 1);
        cmp_range("abort_gamma_hi", 1, 48, CH-1, 512, 1);
        cmp_range("abort_zeta", 2, 0, CH-1, 1024, 1);
        mode = 1'b0;
        @(negedge clk);
        check("reload_err_clr", 16'(load_err), 16'h0);
        check("reload_ready", 16'(para_ready), 16'h1);
        $display("step abort: checks=%0d failures=%0d", checks, failures);

        // Asynchronous reset in LOAD_GAMMA
        do_beats(0, 70, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 16'(para_ready), 16'h0);
        check("arst_done", 16'(para_done), 16'h0);
        check("arst_pvalid", 16'(params_valid), 16'h0);
        check("arst_err", 16'(load_err), 16'h0);
        cmp_range("arst_beta", 0, 0, CH-1, 0, 0);
        cmp_range("arst_gamma", 1, 0, CH-1, 0, 0);
        cmp_range("arst_zeta", 2, 0, CH-1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 16'(para_ready), 16'h1);
        do_beats(0, 1, 16'h0100, 1'b0);
        check("post_rst_beta7", 16'(beta[7]), 16'h0107);
        check("post_rst_beta8", 16'(beta[8]), 16'h0000);
        $display("step async reset: checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
